// File: rtl/iter_mult_acc.sv
// Iterative signed/unsigned WIDTH x WIDTH -> 2*WIDTH multiplier for the HI/LO path.
// It retires BITS_PER_CYCLE multiplier bits per CALC cycle and stops early once
// the remaining multiplier bits are zero. MUL, MADD and MSUB are supported
// against a caller-supplied accumulator. Operands and results use valid/ready
// handshakes, and cancel aborts an in-flight operation.
module iter_mult_acc #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 signed_op,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     op1,
  input  logic [WIDTH-1:0]     op2,
  input  logic [2*WIDTH-1:0]   acc_in,
  input  logic                 cancel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy
);

  localparam int K  = BITS_PER_CYCLE;
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state;
  logic [W2-1:0]     mcand;      // |op1|, shifted left K bits per step
  logic [WIDTH-1:0]  mplier;     // |op2|, shifted right K bits per step
  logic [W2-1:0]     acc;        // unsigned magnitude of the product
  logic [W2-1:0]     acc_in_q;
  logic [1:0]        mode_q;
  logic              neg;

  logic [WIDTH-1:0]  op1_abs;
  logic [WIDTH-1:0]  op2_abs;
  logic [W2-1:0]     acc_step;
  logic [WIDTH-1:0]  mplier_next;
  logic [W2-1:0]     prod;
  logic [W2-1:0]     fix_value;
  logic              accept;

  // Handshake: only an idle, un-cancelled, out-of-reset unit takes operands.
  assign in_ready = (state == IDLE) & ~cancel & resetn;
  assign accept   = in_valid & in_ready;

  // Operand magnitudes, one shift-add step, and the final sign/mode fix-up.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    op1_abs = op1;
    op2_abs = op2;
    if (signed_op && op1[WIDTH-1]) op1_abs = -op1;
    if (signed_op && op2[WIDTH-1]) op2_abs = -op2;

    acc_step    = acc + mcand * W2'(mplier[K-1:0]);
    mplier_next = mplier >> K;

    prod = neg ? -acc : acc;
    case (mode_q)
      2'b01:   fix_value = acc_in_q + prod;
      2'b10:   fix_value = acc_in_q - prod;
      default: fix_value = prod;
    endcase
  end

  // Control FSM together with the datapath registers it sequences.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (!resetn) begin
      // NOTE: datapath registers are reset as well, so result reads 0 and no stale operand survives reset.
      state     <= IDLE;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      acc_in_q  <= '0;
      mode_q    <= 2'b00;
      neg       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mcand    <= W2'(op1_abs);
            mplier   <= op2_abs;
            neg      <= signed_op & (op1[WIDTH-1] ^ op2[WIDTH-1]);
            mode_q   <= mode;
            acc_in_q <= acc_in;
            acc      <= '0;
            busy     <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          if (cancel) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            acc    <= acc_step;
            mcand  <= mcand << K;
            mplier <= mplier_next;
            if (mplier_next == '0) state <= FIX;
          end
        end
        FIX: begin
          if (cancel) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            result    <= fix_value;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // cancel and out_ready both retire the result slot; cancel just drops it.
          if (cancel || out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_mult_acc.sv
// Self-checking bench for iter_mult_acc: a cycle-level reference model checked
// every cycle, plus directed vectors with hand-computed results and latencies.
`timescale 1ns/1ps
module tb_iter_mult_acc;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          resetn, in_valid, signed_op, cancel, out_ready;
  logic [1:0]    mode;
  logic [W-1:0]  op1, op2;
  logic [2*W-1:0] acc_in;
  logic          in_ready, out_valid, busy;
  logic [2*W-1:0] result;

  // Wider-step instances share operand buses but have their own request line.
  logic          in_valid_p;
  logic          in_ready_k2, out_valid_k2, busy_k2;
  logic          in_ready_k4, out_valid_k4, busy_k4;
  logic [2*W-1:0] result_k2, result_k4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  iter_mult_acc #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .signed_op(signed_op), .mode(mode), .op1(op1), .op2(op2), .acc_in(acc_in),
    .cancel(cancel), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  iter_mult_acc #(.WIDTH(W), .BITS_PER_CYCLE(2)) u_k2 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid_p), .in_ready(in_ready_k2),
    .signed_op(signed_op), .mode(mode), .op1(op1), .op2(op2), .acc_in(acc_in),
    .cancel(1'b0), .out_valid(out_valid_k2), .out_ready(1'b1),
    .result(result_k2), .busy(busy_k2)
  );

  iter_mult_acc #(.WIDTH(W), .BITS_PER_CYCLE(4)) u_k4 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid_p), .in_ready(in_ready_k4),
    .signed_op(signed_op), .mode(mode), .op1(op1), .op2(op2), .acc_in(acc_in),
    .cancel(1'b0), .out_valid(out_valid_k4), .out_ready(1'b1),
    .result(result_k4), .busy(busy_k4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: full-width product, then the mode's accumulate rule.
  function automatic logic [63:0] ref_result(input bit s, input logic [1:0] m,
                                             input logic [31:0] a, input logic [31:0] b,
                                             input logic [63:0] acc);
    longint sa, sb;
    logic [63:0] p;
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      p  = sa * sb;
    end else begin
      p = {32'b0, a} * {32'b0, b};
    end
    case (m)
      2'b01:   return acc + p;
      2'b10:   return acc - p;
      default: return p;
    endcase
  endfunction

  // Accept-to-valid latency: n CALC cycles + FIX + the DONE register.
  function automatic int ref_latency(input bit s, input logic [31:0] b, input int k);
    logic [31:0] mag;
    int p;
    mag = (s && b[31]) ? -b : b;
    p = -1;
    for (int i = 0; i < 32; i++) if (mag[i]) p = i;
    return ((p < 0) ? 1 : (p / k + 1)) + 2;
  endfunction

  // Model state for the K=1 instance.
  bit          armed = 1'b0;
  bit          pending = 1'b0;
  bit          valid_exp = 1'b0;
  int          cyc = 0;
  int          exp_lat = 0;
  logic [63:0] exp_res = '0;
  logic [63:0] last_result = '0;

  // Model update on each rising edge, from the bench's own inputs only.
  always @(posedge clk) begin
    if (!resetn) begin
      armed       = 1'b1;
      pending     = 1'b0;
      valid_exp   = 1'b0;
      last_result = '0;
    end else if (armed) begin
      if (pending) begin
        if (cancel) begin
          pending   = 1'b0;
          valid_exp = 1'b0;
        end else if (valid_exp) begin
          if (out_ready) begin
            pending     = 1'b0;
            valid_exp   = 1'b0;
            last_result = exp_res;
          end
        end else begin
          cyc++;
          if (cyc == exp_lat) valid_exp = 1'b1;
        end
      end else if (in_valid && !cancel) begin
        pending = 1'b1;
        cyc     = 1;
        exp_res = ref_result(signed_op, mode, op1, op2, acc_in);
        exp_lat = ref_latency(signed_op, op2, 1);
      end
    end
  end

  // Per-cycle comparison of the K=1 instance against the model.
  always @(negedge clk) begin
    if (armed) begin
      check("model out_valid", {63'b0, out_valid}, {63'b0, valid_exp});
      check("model busy", {63'b0, busy}, {63'b0, pending});
      check("model in_ready", {63'b0, in_ready}, {63'b0, (!pending && !cancel && resetn)});
      check("model result", result, valid_exp ? exp_res : last_result);
    end
  end

  // One operation on the K=1 instance with literal or model expectations.
  task automatic run_op(input string name, input bit s, input logic [1:0] m,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] acc, input logic [63:0] exp,
                        input int lat_exp);
    int lat;
    signed_op = s; mode = m; op1 = a; op2 = b; acc_in = acc;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'(lat_exp));
    check({name, " result"}, result, exp);
    @(posedge clk); #1;
  endtask

  logic [31:0] ra, rb;
  logic [63:0] racc;
  bit          rs;
  logic [1:0]  rm;
  int          lat_k2, lat_k4, lat, vcount;
  logic [63:0] res_k2, res_k4;

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_valid_p = 1'b0; cancel = 1'b0;
    out_ready = 1'b1; signed_op = 1'b0; mode = 2'b00;
    op1 = '0; op2 = '0; acc_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready low", {63'b0, in_ready}, 64'd0);
    resetn = 1'b1;
    #1;
    check("reset out_valid", {63'b0, out_valid}, 64'd0);
    check("reset busy", {63'b0, busy}, 64'd0);
    check("reset result", result, 64'd0);
    check("reset in_ready", {63'b0, in_ready}, 64'd1);

    // Directed literal vectors.
    run_op("umax",      0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 64'hFFFF_FFFE_0000_0001, 34);
    run_op("s m3x5",    1, 2'b00, 32'hFFFF_FFFD, 32'd5,         64'd0, 64'hFFFF_FFFF_FFFF_FFF1, 5);
    run_op("s min2",    1, 2'b00, 32'h8000_0000, 32'h8000_0000, 64'd0, 64'h4000_0000_0000_0000, 34);
    run_op("s minx1",   1, 2'b00, 32'h8000_0000, 32'd1,         64'd0, 64'hFFFF_FFFF_8000_0000, 3);
    run_op("op2 zero",  0, 2'b00, 32'h0000_1234, 32'd0,         64'd0, 64'd0, 3);
    run_op("op2 one",   0, 2'b00, 32'h0000_ABCD, 32'd1,         64'd0, 64'h0000_ABCD, 3);
    run_op("op2 three", 0, 2'b00, 32'd5,         32'd3,         64'd0, 64'd15, 4);
    run_op("op2 bit16", 0, 2'b00, 32'd3,         32'h0001_0000, 64'd0, 64'h0003_0000, 19);
    run_op("madd",      0, 2'b01, 32'd7,         32'd6,         64'h10, 64'h3A, 5);
    run_op("msub",      1, 2'b10, 32'd2,         32'd3,         64'd0, 64'hFFFF_FFFF_FFFF_FFFA, 4);
    run_op("madd wrap", 0, 2'b01, 32'd1,         32'd1,         64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 3);
    run_op("reserved",  0, 2'b11, 32'd4,         32'd4,         64'h55, 64'd16, 5);

    // Back-pressure in DONE, then a back-to-back accept after the transfer.
    out_ready = 1'b0;
    signed_op = 1'b0; mode = 2'b00; op1 = 32'd7; op2 = 32'd6; acc_in = '0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check("hold latency", 64'(lat), 64'd5);
    repeat (10) begin
      @(posedge clk); #1;
      check("hold result", result, 64'd42);
      check("hold out_valid", {63'b0, out_valid}, 64'd1);
      check("hold in_ready", {63'b0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post transfer in_ready", {63'b0, in_ready}, 64'd1);
    op1 = 32'd3; op2 = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b accepted busy", {63'b0, busy}, 64'd1);
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b latency", 64'(lat), 64'd4);
    check("b2b result", result, 64'd9);
    @(posedge clk); #1;

    // Cancel during the 5th CALC cycle.
    op1 = 32'h1234; op2 = 32'h0000_FFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    cancel = 1'b1;
    #1;
    check("cancel blocks in_ready", {63'b0, in_ready}, 64'd0);
    @(posedge clk); #1;
    cancel = 1'b0;
    check("cancel busy", {63'b0, busy}, 64'd0);
    check("cancel out_valid", {63'b0, out_valid}, 64'd0);
    vcount = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) vcount++;
    end
    check("cancel no result", 64'(vcount), 64'd0);
    check("cancel keeps result", result, 64'd9);

    // Reset mid-CALC.
    op1 = 32'd5; op2 = 32'hFFFF_FFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    check("midreset out_valid", {63'b0, out_valid}, 64'd0);
    check("midreset busy", {63'b0, busy}, 64'd0);
    check("midreset result", result, 64'd0);
    check("midreset in_ready", {63'b0, in_ready}, 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    #1;
    check("post reset in_ready", {63'b0, in_ready}, 64'd1);

    // Wider-step instances.
    signed_op = 1'b0; mode = 2'b00; op1 = 32'hFFFF_FFFF; op2 = 32'hFFFF_FFFF; acc_in = '0;
    in_valid_p = 1'b1;
    @(posedge clk); #1;
    in_valid_p = 1'b0;
    lat = 1; lat_k2 = 0; lat_k4 = 0; res_k2 = '0; res_k4 = '0;
    while ((lat_k2 == 0 || lat_k4 == 0) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid_k2 && lat_k2 == 0) begin lat_k2 = lat; res_k2 = result_k2; end
      if (out_valid_k4 && lat_k4 == 0) begin lat_k4 = lat; res_k4 = result_k4; end
    end
    check("k2 latency", 64'(lat_k2), 64'd18);
    check("k2 result", res_k2, 64'hFFFF_FFFE_0000_0001);
    check("k4 latency", 64'(lat_k4), 64'd10);
    check("k4 result", res_k4, 64'hFFFF_FFFE_0000_0001);
    @(posedge clk); #1;

    // Randomised sweep against the reference arithmetic.
    for (int i = 0; i < 24; i++) begin
      rs   = 1'($urandom_range(0, 1));
      rm   = 2'($urandom_range(0, 3));
      ra   = $urandom;
      rb   = $urandom >> $urandom_range(0, 31);
      if (i % 4 == 0) rb = -rb;
      racc = {$urandom, $urandom};
      run_op("random", rs, rm, ra, rb, racc,
             ref_result(rs, rm, ra, rb, racc), ref_latency(rs, rb, 1));
    end

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/iter_mult_acc.md
# iter_mult_acc

Parametrised iterative multiply / multiply-accumulate unit for the CPU's HI/LO datapath. It produces a signed or unsigned WIDTH×WIDTH → 2·WIDTH product, retiring BITS_PER_CYCLE multiplier bits per cycle, and stops early once the remaining multiplier bits are zero. It supports MUL, MADD and MSUB modes against a caller-supplied 2·WIDTH accumulator. Operands and results use valid/ready handshakes, and a cancel input lets the pipeline abort an operation on exception flush.

## Interface
Parameters:
- WIDTH, 32, operand width; must be a multiple of BITS_PER_CYCLE
- BITS_PER_CYCLE, 1, multiplier bits retired per CALC cycle; legal values 1, 2, 4

Ports:
- clk  in  1  clock; all state updates on the rising edge
- resetn  in  1  synchronous active-low reset
- in_valid  in  1  operand request
- in_ready  out  1  unit can accept; equals (state==IDLE) & ~cancel & resetn
- signed_op  in  1  1 = signed operands, 0 = unsigned
- mode  in  2  00 MUL, 01 MADD, 10 MSUB, 11 reserved (behaves as MUL)
- op1  in  WIDTH  multiplicand
- op2  in  WIDTH  multiplier
- acc_in  in  2·WIDTH  accumulator ({HI,LO}); sampled at accept
- cancel  in  1  abort the current operation
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- result  out  2·WIDTH  final value
- busy  out  1  high in CALC, FIX and DONE

## Operation
- States: IDLE, CALC, FIX, DONE.
- **IDLE → CALC** on accept (in_valid & in_ready). At accept:
  - Register |op1| zero-extended to 2·WIDTH as the multiplicand, and |op2| as the WIDTH-bit multiplier. Absolute values are taken only when signed_op=1; otherwise the raw operands are used.
  - Register neg = signed_op & (op1[WIDTH-1] ^ op2[WIDTH-1]), plus mode and acc_in.
  - Clear the accumulator register.
  - |−2^(WIDTH-1)| is 2^(WIDTH-1), interpreted as unsigned; no overflow special case.
- **CALC**, one step per cycle:
  - acc += multiplicand × multiplier[K-1:0], where K = BITS_PER_CYCLE.
  - multiplicand <<= K; multiplier >>= K (logical shift).
  - Go to FIX when the shifted multiplier is zero; otherwise stay in CALC.
  - A zero multiplier still spends exactly one CALC cycle.
- CALC cycle count n = max(1, ceil((p+1)/K)), where p is the index of the highest set bit of the registered multiplier.
- **FIX**, one cycle:
  - prod = neg ? −acc : acc.
  - result = prod (MUL/reserved), acc_in + prod (MADD), or acc_in − prod (MSUB).
  - All arithmetic is modulo 2^(2·WIDTH).
  - Go to DONE.
- **DONE**: out_valid=1 and result is held stable. On out_ready, return to IDLE. No new operand is accepted before that return, so there is no overlap.
- **cancel**:
  - In CALC, FIX or DONE: go to IDLE on the next edge and clear out_valid. No result is delivered; result keeps its old value.
  - In IDLE: in_ready is forced low, so no accept occurs.
  - cancel overrides out_ready in DONE.
- **Reset** (resetn=0 at an edge), from any state including mid-operation:
  - state=IDLE, out_valid=0, busy=0, result=0, internal registers cleared.
  - in_ready reads 0 while resetn=0.

## Timing
- An accept at edge t places CALC at cycles t+1 … t+n, FIX at t+n+1, and out_valid high from edge t+n+2.
- Worst-case latency (accept to out_valid) is WIDTH/K + 2: 34 cycles for 32/1, 18 cycles for 32/2.
- Minimum latency is 3 cycles (op2 = 0 or 1).
- A transfer happens on out_valid & out_ready at edge u. Then in_ready is high in cycle u+1, and the next accept can occur at edge u+1.
- out_valid, result and busy are registered outputs. in_ready is combinational from state, cancel and resetn only.
- Throughput with out_ready tied high: one operation per n+3 cycles.

## Test plan
- Unsigned max operands, WIDTH=32, K=1: signed_op=0, MUL, 0xFFFFFFFF × 0xFFFFFFFF -> result 0xFFFFFFFE00000001, out_valid exactly 34 cycles after accept, busy high throughout.
- Signed corners:
  - −3 × 5 -> 0xFFFFFFFFFFFFFFF1.
  - 0x80000000 × 0x80000000 -> 0x4000000000000000.
  - 0x80000000 × 0x00000001 -> 0xFFFFFFFF80000000.
- Early termination:
  - op2=0 -> result 0, out_valid at accept+3.
  - op2=1 -> out_valid at accept+3.
  - op2=3 -> out_valid at accept+4.
  - op2=0x00010000 -> out_valid at accept+19.
- Accumulate modes:
  - MADD, acc_in=0x10, unsigned 7×6 -> 0x3A.
  - MSUB, acc_in=0, signed 2×3 -> 0xFFFFFFFFFFFFFFFA.
  - MADD, acc_in=0xFFFFFFFFFFFFFFFF, 1×1 -> 0 (wrap).
- Handshake, cancel and reset:
  - Hold out_ready low 10 cycles in DONE -> result stable, in_ready=0. Then pulse out_ready -> IDLE, and a back-to-back accept on the next edge succeeds.
  - cancel in the 5th CALC cycle -> IDLE next cycle, no out_valid.
  - resetn low mid-CALC -> all outputs at reset values.
- Parameterisation: BITS_PER_CYCLE=2 and 4 with 0xFFFFFFFF × 0xFFFFFFFF -> same product, out_valid at accept+18 and accept+10 respectively. Plus a randomized sweep checked against the mode's reference arithmetic (product, acc_in ± product) in both signed and unsigned modes.
